// File: rtl/melody_judge_module_if.sv
// Player-facing bundle of melody_judge_module: raw note keys and the downstream
// busy indication in, verdict pulses and round status out.
interface melody_judge_module_if;
    logic [3:0] key_in;
    logic       busy;
    logic       success;
    logic       fail;
    logic       clear;
    logic [3:0] level;
    logic [3:0] progress;

    modport master (
        output key_in,
        output busy,
        input  success,
        input  fail,
        input  clear,
        input  level,
        input  progress
    );

    modport slave (
        input  key_in,
        input  busy,
        output success,
        output fail,
        output clear,
        output level,
        output progress
    );
endinterface

// File: rtl/melody_judge_module.sv
// melody_judge_module: debounces four note keys, checks each press against the
// answer melody and reports success/fail/clear pulses for the feedback jingle.
// Input is ignored from a verdict until the jingle has started and finished.
module melody_judge_module #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          START_INDEX     = 2,
    parameter int          MAX_INDEX       = 7,
    parameter logic [31:0] MELODY          = 32'h21234321
) (
    input logic                  clk,
    input logic                  reset,
    melody_judge_module_if.slave bus
);

    localparam int              CNT_W       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      START_LEVEL = 4'(START_INDEX);
    localparam logic [3:0]      MAX_LEVEL   = 4'(MAX_INDEX);

    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        WAIT_PLAY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [3:0]       stable;
    logic [3:0]       press_evt;
    logic [CNT_W-1:0] db_cnt [4];

    logic [3:0]       note;
    logic [3:0]       expected_note;

    logic             success_r;
    logic             fail_r;
    logic             clear_r;
    logic [3:0]       level_r;
    logic [3:0]       progress_r;

    // Two-flop synchronizer followed by a per-key debouncer; a press event is the
    // single cycle in which a key's accepted level rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1    <= '0;
            sync_2    <= '0;
            stable    <= '0;
            press_evt <= '0;
            for (int k = 0; k < 4; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync_1 <= bus.key_in;
            sync_2 <= sync_1;
            for (int k = 0; k < 4; k++) begin
                press_evt[k] <= 1'b0;
                if (sync_2[k] != stable[k]) begin
                    if (db_cnt[k] == CNT_LAST) begin
                        stable[k]    <= sync_2[k];
                        db_cnt[k]    <= '0;
                        press_evt[k] <= sync_2[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // Decode the press events into a note code; zero or several simultaneous
    // events decode to 0, which never matches a legal melody note.
    always_comb begin
        note = 4'd0;
        unique case (press_evt)
            4'b0001: note = 4'd1;
            4'b0010: note = 4'd2;
            4'b0100: note = 4'd3;
            4'b1000: note = 4'd4;
            default: note = 4'd0;
        endcase
        expected_note = MELODY[{progress_r[2:0], 2'b00} +: 4];
    end

    // Judging state machine: compare notes in ACCEPT, then sit out the jingle
    // by waiting for busy to rise and fall again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCEPT;
            success_r  <= 1'b0;
            fail_r     <= 1'b0;
            clear_r    <= 1'b0;
            level_r    <= START_LEVEL;
            progress_r <= 4'd0;
        end else begin
            success_r <= 1'b0;
            fail_r    <= 1'b0;
            clear_r   <= 1'b0;
            unique case (state)
                ACCEPT: begin
                    if (|press_evt) begin
                        if (note == expected_note) begin
                            if (progress_r < level_r) begin
                                progress_r <= progress_r + 4'd1;
                            end else begin
                                success_r  <= 1'b1;
                                progress_r <= 4'd0;
                                state      <= WAIT_PLAY;
                                if (level_r < MAX_LEVEL) begin
                                    level_r <= level_r + 4'd1;
                                end else begin
                                    level_r <= START_LEVEL;
                                    clear_r <= 1'b1;
                                end
                            end
                        end else begin
                            fail_r     <= 1'b1;
                            progress_r <= 4'd0;
                            state      <= WAIT_PLAY;
                        end
                    end
                end
                WAIT_PLAY: begin
                    if (bus.busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.busy) begin
                        state <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    assign bus.success  = success_r;
    assign bus.fail     = fail_r;
    assign bus.clear    = clear_r;
    assign bus.level    = level_r;
    assign bus.progress = progress_r;

endmodule

// File: tb/tb_melody_judge_module.sv
// Testbench for melody_judge_module with a short debounce window. A behavioural
// model of the game rules predicts every output each cycle; directed scenarios
// add hand-computed expectations on level, progress and pulse counts.
module tb_melody_judge_module;

    localparam int DB        = 4;
    localparam int START_LVL = 2;
    localparam int MAX_LVL   = 7;

    logic clk;
    logic reset;

    melody_judge_module_if bus_if ();

    melody_judge_module #(
        .DEBOUNCE_CYCLES(DB),
        .START_INDEX    (START_LVL),
        .MAX_INDEX      (MAX_LVL),
        .MELODY         (32'h21234321)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    // Answer melody read nibble by nibble from 32'h21234321, lowest nibble first.
    int melody_notes [8] = '{1, 2, 3, 4, 3, 2, 1, 2};

    int checks = 0;
    int errors = 0;

    int success_seen = 0;
    int fail_seen    = 0;
    int clear_seen   = 0;

    // Model state
    bit [3:0] m_hist0, m_hist1;
    bit       m_stable [4];
    int       m_run    [4];
    bit [3:0] m_pending;
    int       m_mode;
    int       m_level    = START_LVL;
    int       m_progress = 0;
    bit       m_success  = 0;
    bit       m_fail     = 0;
    bit       m_clear    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_hist0    = '0;
        m_hist1    = '0;
        m_pending  = '0;
        m_mode     = 0;
        m_level    = START_LVL;
        m_progress = 0;
        m_success  = 0;
        m_fail     = 0;
        m_clear    = 0;
        for (int k = 0; k < 4; k++) begin
            m_stable[k] = 0;
            m_run[k]    = 0;
        end
    endtask

    task automatic modelStep(input bit [3:0] keys, input bit busy_now);
        bit [3:0] delayed;
        bit [3:0] events;
        bit [3:0] fresh;
        int       note;
        delayed = m_hist1;
        events  = m_pending;
        fresh   = '0;
        // A key level is accepted once it has differed from the accepted level
        // for DB consecutive cycles; only accepted rises count as presses.
        for (int k = 0; k < 4; k++) begin
            if (delayed[k] != m_stable[k]) begin
                if (m_run[k] == DB - 1) begin
                    m_stable[k] = delayed[k];
                    m_run[k]    = 0;
                    fresh[k]    = delayed[k];
                end else begin
                    m_run[k]++;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_pending = fresh;
        m_hist1   = m_hist0;
        m_hist0   = keys;

        m_success = 0;
        m_fail    = 0;
        m_clear   = 0;
        if (m_mode == 0) begin
            if (events != 0) begin
                note = 0;
                if ($countones(events) == 1) begin
                    for (int k = 0; k < 4; k++) if (events[k]) note = k + 1;
                end
                if (note == melody_notes[m_progress]) begin
                    if (m_progress < m_level) begin
                        m_progress++;
                    end else begin
                        m_success  = 1;
                        m_progress = 0;
                        m_mode     = 1;
                        if (m_level < MAX_LVL) m_level++;
                        else begin
                            m_level = START_LVL;
                            m_clear = 1;
                        end
                    end
                end else begin
                    m_fail     = 1;
                    m_progress = 0;
                    m_mode     = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (busy_now) m_mode = 2;
        end else begin
            if (!busy_now) m_mode = 0;
        end
    endtask

    // Model advances on every clock edge and resets asynchronously with the DUT.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelReset();
            else modelStep(bus_if.key_in, bus_if.busy);
        end
    end

    // Compare process: every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("success",  int'(bus_if.success),  int'(m_success));
            checkOutput("fail",     int'(bus_if.fail),     int'(m_fail));
            checkOutput("clear",    int'(bus_if.clear),    int'(m_clear));
            checkOutput("level",    int'(bus_if.level),    m_level);
            checkOutput("progress", int'(bus_if.progress), m_progress);
            if (bus_if.success) success_seen++;
            if (bus_if.fail)    fail_seen++;
            if (bus_if.clear)   clear_seen++;
        end
    end

    // Drive inputs for a number of cycles; always called at posedge + 2.
    task automatic applyStimulus(input logic [3:0] keys, input logic busy_v, input int cycles);
        bus_if.key_in = keys;
        bus_if.busy   = busy_v;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic pressNote(input int note);
        logic [3:0] mask;
        mask = 4'(1 << (note - 1));
        applyStimulus(mask, 1'b0, 10);
        applyStimulus(4'b0000, 1'b0, 10);
    endtask

    task automatic busyHandshake();
        applyStimulus(4'b0000, 1'b1, 3);
        applyStimulus(4'b0000, 1'b0, 3);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 2);
        reset = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1);
    endtask

    task automatic playRound(input int lvl);
        for (int i = 0; i <= lvl; i++) pressNote(melody_notes[i]);
    endtask

    int s0, f0, c0;

    initial begin
        reset         = 1'b1;
        bus_if.key_in = 4'b0000;
        bus_if.busy   = 1'b0;
        @(posedge clk);
        #2;
        doReset();
        checkOutput("reset_level",    int'(bus_if.level),    2);
        checkOutput("reset_progress", int'(bus_if.progress), 0);

        // 1: glitch shorter than the debounce window, then a real press.
        applyStimulus(4'b0001, 1'b0, 3);
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("glitch_progress", int'(bus_if.progress), 0);
        pressNote(1);
        checkOutput("press_progress", int'(bus_if.progress), 1);

        // 2: full round at level 2, presses ignored until jingle handshake ends.
        doReset();
        s0 = success_seen;
        playRound(2);
        checkOutput("round2_success_count", success_seen - s0, 1);
        checkOutput("round2_level",         int'(bus_if.level),    3);
        checkOutput("round2_progress",      int'(bus_if.progress), 0);
        pressNote(1);
        checkOutput("waitplay_no_pulse",     success_seen - s0,     1);
        checkOutput("waitplay_progress",     int'(bus_if.progress), 0);
        busyHandshake();
        pressNote(1);
        checkOutput("after_handshake_progress", int'(bus_if.progress), 1);

        // 3: wrong second note.
        doReset();
        f0 = fail_seen;
        pressNote(1);
        pressNote(4);
        checkOutput("wrong_fail_count", fail_seen - f0,        1);
        checkOutput("wrong_level",      int'(bus_if.level),    2);
        checkOutput("wrong_progress",   int'(bus_if.progress), 0);
        busyHandshake();

        // 4: two keys accepted in the same cycle.
        doReset();
        f0 = fail_seen;
        s0 = success_seen;
        applyStimulus(4'b0011, 1'b0, 10);
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("double_fail_count",    fail_seen - f0,    1);
        checkOutput("double_success_count", success_seen - s0, 0);
        busyHandshake();

        // 5: play all rounds up to the last one; final success clears the game.
        doReset();
        for (int lvl = START_LVL; lvl < MAX_LVL; lvl++) begin
            playRound(lvl);
            busyHandshake();
        end
        checkOutput("top_level", int'(bus_if.level), 7);
        s0 = success_seen;
        c0 = clear_seen;
        playRound(MAX_LVL);
        checkOutput("final_success_count", success_seen - s0, 1);
        checkOutput("final_clear_count",   clear_seen - c0,   1);
        checkOutput("final_level",         int'(bus_if.level), 2);
        busyHandshake();

        // 6: reset while waiting for the jingle to end at level 5.
        doReset();
        for (int lvl = START_LVL; lvl < 5; lvl++) begin
            if (lvl > START_LVL) busyHandshake();
            playRound(lvl);
        end
        checkOutput("pre_reset_level", int'(bus_if.level), 5);
        applyStimulus(4'b0000, 1'b1, 3);
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 2);
        checkOutput("mid_reset_level",    int'(bus_if.level),    2);
        checkOutput("mid_reset_progress", int'(bus_if.progress), 0);
        checkOutput("mid_reset_success",  int'(bus_if.success),  0);
        reset = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1);
        pressNote(1);
        checkOutput("post_reset_progress", int'(bus_if.progress), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_judge_module.md
Name: melody_judge_module

Overview:
- Upstream stage of play_music_module. Debounces four player note keys and compares each press against a fixed answer melody.
- Emits the one-cycle success/fail pulses that trigger the feedback jingle downstream.
- Owns the round length (last_index, growing 2..7) and the player's position within the round.
- Ignores key input while the jingle plays, using the downstream busy (is_music_playing) indication.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of cycles a synchronized key level must differ from the stable level before being accepted (10 ms at 50 MHz).
- START_INDEX, 2, last_index value after reset and after a cleared game.
- MAX_INDEX, 7, highest last_index. Must satisfy START_INDEX <= MAX_INDEX <= 7.
- MELODY, 32'h21234321, answer ROM: note for index i in bits [4i+3:4i]; legal codes 1..4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_in  input  4  raw asynchronous active-high buttons; bit k means note code k+1
- busy  input  1  high while downstream jingle plays
- success  output  1  one-cycle pulse: round completed correctly
- fail  output  1  one-cycle pulse: wrong note entered
- clear  output  1  one-cycle pulse, coincident with success, when the MAX_INDEX round is completed
- level  output  4  current last_index
- progress  output  4  index of the next expected note (0..level)

Behaviour:
- Reset (async, any state): success=fail=clear=0, level=START_INDEX, progress=0, state=ACCEPT, debounce counters=0, stable key levels=0, sync flops=0.
- Synchronizer: each key_in bit passes through 2 flops.
- Debounce, per key: if sync != stable, the counter increments; when the counter equals DEBOUNCE_CYCLES-1 on that edge, stable <= sync and the counter clears. If sync == stable, the counter clears. Counter width = clog2(DEBOUNCE_CYCLES)+1.
- A press event is a rising edge of stable, one cycle wide. Debouncers run in every state.
- State machine:
  - ACCEPT: press events are evaluated. Exactly one event bit k raised this cycle gives note = k+1. Two or more raised in the same cycle count as a wrong note. No event: hold.
  - Correct note, progress < level: progress <= progress+1, stay in ACCEPT, no pulse.
  - Correct note, progress == level: success=1 next cycle, progress <= 0.
    - If level < MAX_INDEX: level <= level+1.
    - Else: level <= START_INDEX and clear=1 with success.
    - Go to WAIT_PLAY.
  - Wrong note: fail=1 next cycle, progress <= 0, level unchanged, go to WAIT_PLAY.
  - WAIT_PLAY: press events are discarded; go to WAIT_DONE when busy==1.
  - WAIT_DONE: press events are discarded; go to ACCEPT when busy==0.
- Latency: a verdict pulse is registered one cycle after the press event cycle. The press event occurs 2 sync cycles + DEBOUNCE_CYCLES after the raw edge.
- success and fail are never high together. Pulses last exactly one cycle.
- Release edges (stable 1->0) produce no event.
- busy is ignored in ACCEPT.
- If busy is already high when entering WAIT_PLAY, the move to WAIT_DONE happens on the next cycle.
- Reset mid-WAIT or mid-round returns to ACCEPT with level=START_INDEX and progress=0.
- A stable key held high produces no repeat events; it must be released and pressed again.

Test Plan:
1. DEBOUNCE_CYCLES=4. Hold key_in=4'b0001 for 3 cycles, then release -> no press event, progress stays 0. Hold for 10 cycles -> exactly one event; progress 0->1 (MELODY[0]=1).
2. After reset, press keys for notes 1,2,3 (bits 0,1,2) -> success pulses once, 1 cycle wide; level 2->3; progress 0; state WAIT_PLAY. A key press before busy rises and falls gives no pulse. After busy 1 then 0, presses are accepted again.
3. Reset, then press note 1 followed by note 4 -> fail pulse one cycle after the second event; level stays 2; progress=0.
4. Bits 0 and 1 debounced in the same cycle while in ACCEPT -> fail pulse, not success.
5. Force level=7 by completing rounds 2..7 with notes 1,2,3,4,3,2,1,2 (busy handshake after each) -> final success and clear coincide; level returns to 2.
6. Assert reset during WAIT_DONE at level 5 -> success=fail=clear=0, level=2, progress=0. The next correct note 1 advances progress to 1 without any busy handshake.
